// File: rtl/mips_debug_pkg.sv
// Shared constants and state encoding for the MIPS host debug controller.
package mips_debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_RESET = 8'h52;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned BYTE_CNT_W      = 3;
  localparam int unsigned IDX_W           = 8;
  localparam int unsigned N_SPECIAL_ITEMS = 2;
  localparam int unsigned N_REG_ITEMS     = 32;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_COUNT,
    LOAD_BYTE,
    LOAD_WRITE,
    STEP,
    RUN,
    DUMP_SEL,
    DUMP_LATCH,
    DUMP_SEND,
    ACK
  } state_e;

endpackage

// File: rtl/debug_word_serializer.sv
// Splits a word into link bytes, MSB first; a 1-byte load sends only the top byte.
module debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int unsigned NB      = 32,
  parameter int unsigned NB_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NB-1:0]         word_i,
  input  logic [BYTE_CNT_W-1:0] nbytes_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [NB_DATA-1:0]    tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i
);

  logic [NB-1:0]         shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] count_q, count_d;
  logic                  valid_q;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (count_q == '0) begin
      if (in_valid_i) begin
        shift_d = word_i;
        count_d = nbytes_i;
      end
    end else if (tx_ready_i) begin
      shift_d = shift_q << NB_DATA;
      count_d = count_q - BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign tx_data_o  = shift_q[NB-1 -: NB_DATA];
  assign tx_valid_o = valid_q;
  assign in_ready_o = ~valid_q;

endmodule

// File: rtl/mips_debug_controller.sv
// Host-link command decoder: loads instruction memory, steps/runs/resets the
// pipeline and streams a full state dump after every step or run.
module mips_debug_controller
  import mips_debug_pkg::*;
#(
  parameter int unsigned NB          = 32,
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_REGS     = 5,
  parameter int unsigned N_MEM_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  input  logic [NB-1:0]      i_mips_pc,
  input  logic [NB-1:0]      i_mips_alu_result,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic [NB-1:0]      i_mips_data_memory,
  input  logic               i_halt,
  output logic               o_step,
  output logic               o_mips_reset,
  output logic               o_instruction_write_enable,
  output logic [NB-1:0]      o_instruction_address,
  output logic [NB-1:0]      o_instruction_data,
  output logic [NB_REGS-1:0] o_debug_mips_register_number,
  output logic [NB-1:0]      o_debug_address
);

  localparam int unsigned N_ITEMS = N_SPECIAL_ITEMS + N_REG_ITEMS + N_MEM_WORDS;
  localparam int unsigned ITEM_W  = $clog2(N_ITEMS);
  localparam logic [ITEM_W-1:0] REG_FIRST = ITEM_W'(N_SPECIAL_ITEMS);
  localparam logic [ITEM_W-1:0] MEM_FIRST = ITEM_W'(N_SPECIAL_ITEMS + N_REG_ITEMS);
  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(N_ITEMS - 1);

  state_e              state_q, state_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [NB-1:0]       instr_q, instr_d;
  logic [NB_DATA-1:0]  ack_q, ack_d;
  logic                mips_reset_q, mips_reset_d;
  logic                we_q, we_d;
  logic [NB-1:0]       iaddr_q, iaddr_d;
  logic [NB_REGS-1:0]  reg_num_q, reg_num_d;
  logic [NB-1:0]       dbg_addr_q, dbg_addr_d;

  logic                  ser_valid;
  logic                  ser_ready;
  logic [NB-1:0]         ser_word;
  logic [BYTE_CNT_W-1:0] ser_nbytes;

  always_comb begin
    state_d      = state_q;
    item_d       = item_q;
    byte_cnt_d   = byte_cnt_q;
    index_d      = index_q;
    count_d      = count_q;
    instr_d      = instr_q;
    ack_d        = ack_q;
    mips_reset_d = 1'b0;
    we_d         = 1'b0;
    ser_valid    = 1'b0;
    ser_word     = '0;
    ser_nbytes   = '0;
    reg_num_d    = reg_num_q;
    dbg_addr_d   = dbg_addr_q;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              mips_reset_d = 1'b1;
              index_d      = '0;
              state_d      = LOAD_COUNT;
            end
            CMD_STEP:  state_d = STEP;
            CMD_RUN:   state_d = RUN;
            CMD_RESET: begin
              mips_reset_d = 1'b1;
              ack_d        = CMD_RESET;
              state_d      = ACK;
            end
            default: ;
          endcase
        end
      end
      LOAD_COUNT: begin
        if (i_rx_valid) begin
          count_d    = i_rx_data;
          byte_cnt_d = '0;
          state_d    = LOAD_BYTE;
        end
      end
      LOAD_BYTE: begin
        if (i_rx_valid) begin
          instr_d    = {instr_q[NB-NB_DATA-1:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            state_d = LOAD_WRITE;
          end
        end
      end
      LOAD_WRITE: begin
        // A count of 0 means 256 words: the 8-bit index wraps back to 0.
        index_d = index_q + IDX_W'(1);
        if (index_d == count_q) begin
          ack_d   = CMD_LOAD;
          state_d = ACK;
        end else begin
          state_d = LOAD_BYTE;
        end
      end
      STEP: begin
        item_d  = '0;
        state_d = DUMP_SEL;
      end
      RUN: begin
        if (i_halt) begin
          item_d  = '0;
          state_d = DUMP_SEL;
        end
      end
      DUMP_SEL: state_d = DUMP_LATCH;
      DUMP_LATCH: begin
        if (ser_ready) begin
          ser_valid  = 1'b1;
          ser_nbytes = BYTE_CNT_W'(BYTES_PER_WORD);
          if (item_q == '0)            ser_word = i_mips_pc;
          else if (item_q < REG_FIRST) ser_word = i_mips_alu_result;
          else if (item_q < MEM_FIRST) ser_word = i_mips_register_data;
          else                         ser_word = i_mips_data_memory;
          state_d = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (ser_ready) begin
          if (item_q == ITEM_LAST) begin
            item_d  = '0;
            state_d = IDLE;
          end else begin
            item_d  = item_q + ITEM_W'(1);
            state_d = DUMP_SEL;
          end
        end
      end
      ACK: begin
        if (ser_ready) begin
          ser_valid  = 1'b1;
          ser_nbytes = BYTE_CNT_W'(1);
          ser_word   = {ack_q, {(NB-NB_DATA){1'b0}}};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Selects follow the item about to be dumped so they settle during DUMP_SEL.
    if (item_d >= REG_FIRST && item_d < MEM_FIRST) reg_num_d = NB_REGS'(item_d - REG_FIRST);
    if (item_d >= MEM_FIRST) dbg_addr_d = NB'({item_d - MEM_FIRST, 2'b00});
    iaddr_d = NB'({index_d, 2'b00});
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      item_q       <= '0;
      byte_cnt_q   <= '0;
      index_q      <= '0;
      count_q      <= '0;
      instr_q      <= '0;
      ack_q        <= '0;
      mips_reset_q <= 1'b0;
      we_q         <= 1'b0;
      iaddr_q      <= '0;
      reg_num_q    <= '0;
      dbg_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      item_q       <= item_d;
      byte_cnt_q   <= byte_cnt_d;
      index_q      <= index_d;
      count_q      <= count_d;
      instr_q      <= instr_d;
      ack_q        <= ack_d;
      mips_reset_q <= mips_reset_d;
      we_q         <= we_d;
      iaddr_q      <= iaddr_d;
      reg_num_q    <= reg_num_d;
      dbg_addr_q   <= dbg_addr_d;
    end
  end

  debug_word_serializer #(
    .NB      (NB),
    .NB_DATA (NB_DATA)
  ) u_serializer (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .word_i     (ser_word),
    .nbytes_i   (ser_nbytes),
    .in_valid_i (ser_valid),
    .in_ready_o (ser_ready),
    .tx_data_o  (o_tx_data),
    .tx_valid_o (o_tx_valid),
    .tx_ready_i (i_tx_ready)
  );

  // Step gating is combinational so a halted pipeline never sees an advance.
  assign o_step = ((state_q == STEP) || (state_q == RUN)) && !i_halt;

  assign o_mips_reset                 = mips_reset_q;
  assign o_instruction_write_enable   = we_q;
  assign o_instruction_address        = iaddr_q;
  assign o_instruction_data           = instr_q;
  assign o_debug_mips_register_number = reg_num_q;
  assign o_debug_address              = dbg_addr_q;

endmodule

// File: tb/tb_mips_debug_controller.sv
// Scoreboard bench for mips_debug_controller: expected TX bytes and instruction
// writes are queued by the stimulus and checked by an independent monitor.
module tb_mips_debug_controller;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [31:0] i_mips_pc, i_mips_alu_result, i_mips_register_data, i_mips_data_memory;
  logic        i_halt;
  logic        o_step, o_mips_reset, o_instruction_write_enable;
  logic [31:0] o_instruction_address, o_instruction_data, o_debug_address;
  logic [4:0]  o_debug_mips_register_number;

  mips_debug_controller dut (
    .i_clk                        (i_clk),
    .i_reset                      (i_reset),
    .i_rx_data                    (i_rx_data),
    .i_rx_valid                   (i_rx_valid),
    .o_tx_data                    (o_tx_data),
    .o_tx_valid                   (o_tx_valid),
    .i_tx_ready                   (i_tx_ready),
    .i_mips_pc                    (i_mips_pc),
    .i_mips_alu_result            (i_mips_alu_result),
    .i_mips_register_data         (i_mips_register_data),
    .i_mips_data_memory           (i_mips_data_memory),
    .i_halt                       (i_halt),
    .o_step                       (o_step),
    .o_mips_reset                 (o_mips_reset),
    .o_instruction_write_enable   (o_instruction_write_enable),
    .o_instruction_address        (o_instruction_address),
    .o_instruction_data           (o_instruction_data),
    .o_debug_mips_register_number (o_debug_mips_register_number),
    .o_debug_address              (o_debug_address)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bytes_seen = 0, writes_seen = 0, rst_pulses = 0, step_cycles = 0;
  bit rand_ready = 1'b0;

  logic [7:0]  exp_q[$];
  logic [63:0] wr_q[$];

  // Pipeline model: register r3 holds 7, other registers and memory hold tagged patterns.
  function automatic logic [31:0] reg_val(input logic [4:0] r);
    return (r == 5'd3) ? 32'h0000_0007 : (32'h5500_0000 | 32'(r));
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {16'hBEEF, a[15:0]};
  endfunction

  assign i_mips_register_data = reg_val(o_debug_mips_register_number);
  assign i_mips_data_memory   = mem_val(o_debug_address);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] alu);
    push_word(pc);
    push_word(alu);
    for (int r = 0; r < 32; r++) push_word(reg_val(5'(r)));
    for (int m = 0; m < 16; m++) push_word(mem_val(32'(m * 4)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    repeat (10) @(posedge i_clk);
    #1;
    check({name, "_tx_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
    check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({name, "_step"}, 32'(o_step), 32'd0);
    check({name, "_mips_reset"}, 32'(o_mips_reset), 32'd0);
    check({name, "_we"}, 32'(o_instruction_write_enable), 32'd0);
    check({name, "_iaddr"}, o_instruction_address, 32'd0);
    check({name, "_idata"}, o_instruction_data, 32'd0);
    check({name, "_regnum"}, 32'(o_debug_mips_register_number), 32'd0);
    check({name, "_dbgaddr"}, o_debug_address, 32'd0);
  endtask

  // Ready driver: random backpressure when enabled.
  always @(posedge i_clk) begin
    #2;
    i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled on the falling edge, between input drives.
  logic       hold_valid = 1'b0;
  logic [7:0] hold_data  = 8'h00;
  always @(negedge i_clk) begin
    if (!i_reset) begin
      hold_valid = 1'b0;
    end else begin
      if (o_tx_valid && hold_valid) check("tx_stable", 32'(o_tx_data), 32'(hold_data));
      if (o_tx_valid && i_tx_ready) begin
        bytes_seen++;
        hold_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check("tx_unexpected", 32'(o_tx_data), 32'h100);
        end else begin
          check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
      end else if (o_tx_valid) begin
        hold_valid = 1'b1;
        hold_data  = o_tx_data;
      end
      if (o_instruction_write_enable) begin
        logic [63:0] w;
        writes_seen++;
        w = {o_instruction_address, o_instruction_data};
        if (wr_q.size() == 0) check("wr_unexpected", o_instruction_address, 32'hFFFF_FFFF);
        else check("wr_addr_data_hi", w[63:32], wr_q[0][63:32]);
        if (wr_q.size() != 0) check("wr_data", w[31:0], wr_q.pop_front()[31:0]);
      end
      if (o_mips_reset) rst_pulses++;
      if (o_step) step_cycles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, s0, r0, w0;
    i_reset = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_halt = 1'b0;
    i_mips_pc = 32'h0; i_mips_alu_result = 32'h0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_reset = 1'b1;

    // Load two words.
    r0 = rst_pulses; w0 = writes_seen; b0 = bytes_seen;
    wr_q.push_back({32'h0, 32'h1234_5678});
    wr_q.push_back({32'h4, 32'h9ABC_DEF0});
    exp_q.push_back(8'h4C);
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    drain("load", 200);
    check("load_reset_pulses", 32'(rst_pulses - r0), 32'd1);
    check("load_writes", 32'(writes_seen - w0), 32'd2);
    check("load_ack_bytes", 32'(bytes_seen - b0), 32'd1);

    // Single step then dump.
    i_mips_pc = 32'h4; i_mips_alu_result = 32'h1234_ABCD;
    s0 = step_cycles; b0 = bytes_seen;
    push_dump(32'h4, 32'h1234_ABCD);
    send_byte(8'h53);
    drain("step", 1000);
    check("step_cycles", 32'(step_cycles - s0), 32'd1);
    check("step_dump_bytes", 32'(bytes_seen - b0), 32'd200);

    // Run until halt rises 10 cycles after the command.
    i_mips_pc = 32'h20; i_mips_alu_result = 32'hCAFE_0001;
    s0 = step_cycles; b0 = bytes_seen;
    push_dump(32'h20, 32'hCAFE_0001);
    send_byte(8'h43);
    repeat (10) @(posedge i_clk);
    #1 i_halt = 1'b1;
    drain("run", 1000);
    check("run_step_cycles", 32'(step_cycles - s0), 32'd10);
    check("run_dump_bytes", 32'(bytes_seen - b0), 32'd200);
    i_halt = 1'b0;

    // Step under random backpressure, with a stray 'S' during the dump.
    rand_ready = 1'b1;
    i_mips_pc = 32'h44; i_mips_alu_result = 32'h0BAD_F00D;
    s0 = step_cycles; b0 = bytes_seen;
    push_dump(32'h44, 32'h0BAD_F00D);
    send_byte(8'h53);
    repeat (30) @(posedge i_clk);
    send_byte(8'h53);
    drain("bp_step", 3000);
    check("bp_step_cycles", 32'(step_cycles - s0), 32'd1);
    check("bp_dump_bytes", 32'(bytes_seen - b0), 32'd200);
    rand_ready = 1'b0;

    // Unknown command in IDLE does nothing.
    s0 = step_cycles; b0 = bytes_seen; r0 = rst_pulses;
    send_byte(8'h99);
    repeat (20) @(posedge i_clk);
    #1;
    check("ign_bytes", 32'(bytes_seen - b0), 32'd0);
    check("ign_steps", 32'(step_cycles - s0), 32'd0);
    check("ign_resets", 32'(rst_pulses - r0), 32'd0);

    // Reset in the middle of a load aborts silently.
    w0 = writes_seen;
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    #1 i_reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge i_clk); #1 i_reset = 1'b1;
    r0 = rst_pulses; b0 = bytes_seen;
    exp_q.push_back(8'h52);
    send_byte(8'h52);
    drain("reset_cmd", 200);
    check("reset_cmd_pulses", 32'(rst_pulses - r0), 32'd1);
    check("reset_cmd_bytes", 32'(bytes_seen - b0), 32'd1);
    check("abort_no_write", 32'(writes_seen - w0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
